// File: rtl/esc_pkg.sv
// esc_pkg: shared state type, constants and pulse-width helper for esc_pwm_drv.
package esc_pkg;

    typedef enum logic {ARM, RUN} state_t;

    localparam int          MIN_PULSE_DEF = 50000;
    localparam logic [11:0] SUM_MAX       = 12'd2047;

    // Saturate speed+offset at full scale, then scale by 3 on top of the zero-speed pulse.
    function automatic logic [16:0] width_calc(input logic [10:0] spd,
                                               input logic [9:0]  off,
                                               input logic [16:0] min_pulse);
        logic [11:0] sum;
        logic [10:0] sat;
        sum = {1'b0, spd} + {2'b00, off};
        sat = (sum > SUM_MAX) ? SUM_MAX[10:0] : sum[10:0];
        return min_pulse + (17'(sat) * 17'd3);
    endfunction

endpackage

// File: rtl/esc_chnl.sv
// esc_chnl: one ESC channel - speed shadow, optional slew limiter (SLEW_LIMIT_EN),
// per-period width latch and registered PWM compare.
module esc_chnl
    import esc_pkg::*;
#(
    parameter int PERIOD_W  = 20,
    parameter int MIN_PULSE = MIN_PULSE_DEF
`ifdef SLEW_LIMIT_EN
    , parameter int SLEW_STEP = 32
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spd_vld,
    input  logic [10:0]         spd,
    input  logic [9:0]          off,
    input  logic                latch,
    input  logic                run,
    input  logic [PERIOD_W-1:0] cnt_nxt,
    output logic                pwm
);

    localparam int CW = (PERIOD_W > 17) ? PERIOD_W : 17;

    logic [10:0]   shadow;
    logic [10:0]   fwd;
    logic [10:0]   eff;
    logic [16:0]   width_nxt;
    logic [16:0]   width_lat;
    logic [CW-1:0] cnt_ext;
    logic [CW-1:0] cmp_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            shadow <= '0;
        else if (spd_vld)
            shadow <= spd;
    end

    // A capture landing on the latch cycle must reach the coming period directly.
    assign fwd = spd_vld ? spd : shadow;

`ifdef SLEW_LIMIT_EN
    localparam logic [10:0] STEP = 11'(SLEW_STEP);

    logic [10:0] applied;
    logic [10:0] applied_nxt;

    always_comb begin
        applied_nxt = applied;
        if (!run)
            applied_nxt = '0;
        else if (fwd > applied)
            applied_nxt = ((fwd - applied) > STEP) ? (applied + STEP) : fwd;
        else
            applied_nxt = ((applied - fwd) > STEP) ? (applied - STEP) : fwd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            applied <= '0;
        else if (latch)
            applied <= applied_nxt;
    end

    assign eff = applied_nxt;
`else
    assign eff = fwd;
`endif

    assign width_nxt = run ? width_calc(eff, off, 17'(MIN_PULSE)) : 17'(MIN_PULSE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            width_lat <= '0;
        else if (latch)
            width_lat <= width_nxt;
    end

    // Compare against the count of the next cycle so the flop output is aligned with cnt.
    assign cnt_ext = CW'(cnt_nxt);
    assign cmp_w   = latch ? CW'(width_nxt) : CW'(width_lat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pwm <= 1'b0;
        else
            pwm <= (cnt_ext < cmp_w);
    end

endmodule

// File: rtl/esc_pwm_drv.sv
// esc_pwm_drv: four-channel ESC PWM driver with shared period counter and arming FSM.
// Optional build macro SLEW_LIMIT_EN enables per-channel slew limiting of applied speed.
module esc_pwm_drv
    import esc_pkg::*;
#(
    parameter int PERIOD_W    = 20,
    parameter int MIN_PULSE   = MIN_PULSE_DEF,
    parameter int ARM_PERIODS = 50
`ifdef SLEW_LIMIT_EN
    , parameter int SLEW_STEP = 32
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spd_vld,
    input  logic [10:0] frnt_spd,
    input  logic [10:0] bck_spd,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    input  logic [9:0]  off_frnt,
    input  logic [9:0]  off_bck,
    input  logic [9:0]  off_lft,
    input  logic [9:0]  off_rght,
    output logic        frnt,
    output logic        bck,
    output logic        lft,
    output logic        rght,
    output logic        prd_strt,
    output logic        armed
);

    localparam int AW = (ARM_PERIODS > 1) ? $clog2(ARM_PERIODS) : 1;

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] cnt_nxt;
    logic                wrap;
    state_t              state;
    state_t              state_nxt;
    logic [AW-1:0]       arm_cnt;
    logic [AW-1:0]       arm_cnt_nxt;
    logic                run_nxt;
    logic [10:0]         spd_a [4];
    logic [9:0]          off_a [4];
    logic [3:0]          pwm_a;

    assign cnt_nxt = cnt + 1'b1;
    assign wrap    = &cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            prd_strt <= 1'b0;
            state    <= ARM;
            arm_cnt  <= '0;
        end else begin
            cnt      <= cnt_nxt;
            prd_strt <= wrap;
            state    <= state_nxt;
            arm_cnt  <= arm_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        arm_cnt_nxt = arm_cnt;
        case (state)
            ARM: begin
                if (wrap) begin
                    if (arm_cnt == AW'(ARM_PERIODS - 1))
                        state_nxt = RUN;
                    else
                        arm_cnt_nxt = arm_cnt + 1'b1;
                end
            end
            RUN: state_nxt = RUN;
            default: state_nxt = ARM;
        endcase
    end

    // Widths are latched for the coming period, so they follow the state that period runs in.
    assign run_nxt = (state_nxt == RUN);
    assign armed   = (state == RUN);

    assign spd_a[0] = frnt_spd;
    assign spd_a[1] = bck_spd;
    assign spd_a[2] = lft_spd;
    assign spd_a[3] = rght_spd;
    assign off_a[0] = off_frnt;
    assign off_a[1] = off_bck;
    assign off_a[2] = off_lft;
    assign off_a[3] = off_rght;

    for (genvar k = 0; k < 4; k++) begin : g_chnl
        esc_chnl #(
            .PERIOD_W  (PERIOD_W),
            .MIN_PULSE (MIN_PULSE)
`ifdef SLEW_LIMIT_EN
            , .SLEW_STEP (SLEW_STEP)
`endif
        ) u_chnl (
            .clk     (clk),
            .rst_n   (rst_n),
            .spd_vld (spd_vld),
            .spd     (spd_a[k]),
            .off     (off_a[k]),
            .latch   (wrap),
            .run     (run_nxt),
            .cnt_nxt (cnt_nxt),
            .pwm     (pwm_a[k])
        );
    end

    assign frnt = pwm_a[0];
    assign bck  = pwm_a[1];
    assign lft  = pwm_a[2];
    assign rght = pwm_a[3];

endmodule

// File: tb/tb_esc_pwm_drv.sv
// tb_esc_pwm_drv: table-driven per-period pulse-width checks with a scoreboard queue,
// plus hand-written reset-during-pulse and re-arming sequences (default build).
module tb_esc_pwm_drv;

    localparam int PW   = 13;
    localparam int N    = 1 << PW;
    localparam int MINP = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spd_vld = 1'b0;
    logic [10:0] frnt_spd = '0, bck_spd = '0, lft_spd = '0, rght_spd = '0;
    logic [9:0]  off_frnt = 10'd0, off_bck = 10'h3FF, off_lft = 10'd0, off_rght = 10'd5;
    logic        frnt, bck, lft, rght, prd_strt, armed;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          inj;
        int          inj_at;
        logic [10:0] inj_lft;
        int          w_frnt;
        int          w_bck;
        int          w_lft;
        int          w_rght;
        bit          exp_armed;
    } vec_t;

    vec_t vecs [6];
    vec_t sb [$];

    int act_w [4];
    int strt_seen;
    bit armed_bad;

    always #5 clk = ~clk;

    esc_pwm_drv #(
        .PERIOD_W    (PW),
        .MIN_PULSE   (MINP),
        .ARM_PERIODS (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spd_vld  (spd_vld),
        .frnt_spd (frnt_spd),
        .bck_spd  (bck_spd),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .off_frnt (off_frnt),
        .off_bck  (off_bck),
        .off_lft  (off_lft),
        .off_rght (off_rght),
        .frnt     (frnt),
        .bck      (bck),
        .lft      (lft),
        .rght     (rght),
        .prd_strt (prd_strt),
        .armed    (armed)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic waitStart(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < N + 16; i++) begin
            @(negedge clk);
            if (prd_strt) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("[TB] FAIL prd_strt_timeout: no period start within %0d cycles", N + 16);
        end
    endtask

    // Queue the expectation, then measure one whole period starting at its cnt==0 cycle.
    task automatic applyStimulus(input vec_t v);
        bit ok;
        sb.push_back(v);
        for (int k = 0; k < 4; k++) act_w[k] = 0;
        strt_seen = 0;
        armed_bad = 1'b0;
        waitStart(ok);
        for (int i = 0; i < N; i++) begin
            if (i > 0) @(negedge clk);
            if (frnt) act_w[0]++;
            if (bck)  act_w[1]++;
            if (lft)  act_w[2]++;
            if (rght) act_w[3]++;
            if (prd_strt) strt_seen++;
            if (armed != v.exp_armed) armed_bad = 1'b1;
            if (v.inj && i == v.inj_at) begin
                lft_spd = v.inj_lft;
                spd_vld = 1'b1;
            end else begin
                spd_vld = 1'b0;
            end
        end
        @(posedge clk);
        #1 spd_vld = 1'b0;
    endtask

    task automatic checkPeriod(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_scoreboard: got empty queue, expected an entry", tag);
            return;
        end
        e = sb.pop_front();
        checkOutput({tag, "_frnt"}, act_w[0], e.w_frnt);
        checkOutput({tag, "_bck"},  act_w[1], e.w_bck);
        checkOutput({tag, "_lft"},  act_w[2], e.w_lft);
        checkOutput({tag, "_rght"}, act_w[3], e.w_rght);
        checkOutput({tag, "_prd_strt"}, strt_seen, 1);
        checkOutput({tag, "_armed_stable"}, int'(armed_bad), 0);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;

        // Expected widths: MIN 1000 + 3*clamp(spd+off, 2047); ARM forces 1000.
        vecs[0] = '{0, 0,     11'h000, 1000, 1000, 1000, 1000, 1'b0};
        vecs[1] = '{0, 0,     11'h000, 1768, 7141, 1000, 1015, 1'b1};
        vecs[2] = '{1, 500,   11'h200, 1768, 7141, 1000, 1015, 1'b1};
        vecs[3] = '{1, N - 1, 11'h080, 1768, 7141, 2536, 1015, 1'b1};
        vecs[4] = '{0, 0,     11'h000, 1768, 7141, 1384, 1015, 1'b1};
        vecs[5] = '{0, 0,     11'h000, 1000, 1000, 1000, 1000, 1'b0};

        #23;
        checkOutput("rst_frnt", int'(frnt), 0);
        checkOutput("rst_bck", int'(bck), 0);
        checkOutput("rst_lft", int'(lft), 0);
        checkOutput("rst_rght", int'(rght), 0);
        checkOutput("rst_prd_strt", int'(prd_strt), 0);
        checkOutput("rst_armed", int'(armed), 0);

        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        frnt_spd = 11'h100;
        bck_spd  = 11'h7FF;
        lft_spd  = 11'h000;
        rght_spd = 11'h000;
        spd_vld  = 1'b1;
        @(negedge clk) spd_vld = 1'b0;

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v]);
            checkPeriod($sformatf("period%0d", v + 1));
        end

        // Reset in the middle of live pulses, then confirm arming starts over.
        waitStart(ok);
        for (int i = 1; i <= 500; i++) @(negedge clk);
        checkOutput("pre_rst_frnt_high", int'(frnt), 1);
        checkOutput("pre_rst_bck_high", int'(bck), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_frnt", int'(frnt), 0);
        checkOutput("midrst_bck", int'(bck), 0);
        checkOutput("midrst_lft", int'(lft), 0);
        checkOutput("midrst_rght", int'(rght), 0);
        checkOutput("midrst_armed", int'(armed), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(vecs[5]);
        checkPeriod("rearm_period1");
        waitStart(ok);
        checkOutput("rearm_armed_rise", int'(armed), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
